// File: rtl/mod_mem_lsu_split.sv
// Load/store unit: turns one load/store request into one or two aligned bus beats,
// shifting store data into byte lanes and extracting/extending load data.
module mod_mem_lsu_split #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_error_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0] mem_byteenable_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = XLEN / 8;
  localparam int OFFW     = $clog2(BE_WIDTH);
  localparam int BE2_W    = 2 * BE_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_store;
  logic [2:0]          r_funct3;
  logic [OFFW-1:0]     r_off;
  logic [XLEN-1:0]     r_base;
  logic [BE2_W-1:0]    r_be2;
  logic [2*XLEN-1:0]   r_wdata2;
  logic                r_split;
  logic [XLEN-1:0]     r_rdata0;
  logic [XLEN-1:0]     r_resp_rdata;
  logic                r_resp_error;

  logic [OFFW-1:0]     w_in_off;
  logic [7:0]          w_in_mask8;
  logic [BE2_W-1:0]    w_in_be2;
  logic [2*XLEN-1:0]   w_in_wdata2;
  logic                w_in_split;
  logic                w_in_legal;
  logic                w_accept;
  logic                w_reject;

  logic [XLEN-1:0]     w_rd_lo;
  logic [XLEN-1:0]     w_rd_hi;
  logic [2*XLEN-1:0]   w_rd_cat;
  logic [XLEN-1:0]     w_rd_al;
  logic [6:0]          w_ext_sh;
  logic [XLEN-1:0]     w_rd_left;
  logic [XLEN-1:0]     w_load_val;

  // Geometry of the incoming request, decided before it is accepted
  assign w_in_off    = addr_i[OFFW-1:0];
  assign w_in_be2    = BE2_W'(w_in_mask8) << w_in_off;
  assign w_in_wdata2 = (2*XLEN)'(wdata_i) << {w_in_off, 3'b000};
  assign w_in_split  = |w_in_be2[BE2_W-1:BE_WIDTH];
  assign w_accept    = req_valid_i && (r_state == IDLE);
  assign w_reject    = !w_in_legal || (w_in_split && !SPLIT_MISALIGNED);

  always_comb begin
    w_in_mask8 = 8'h01;
    case (funct3_i[1:0])
      2'b00:   w_in_mask8 = 8'h01;
      2'b01:   w_in_mask8 = 8'h03;
      2'b10:   w_in_mask8 = 8'h0F;
      default: w_in_mask8 = 8'hFF;
    endcase
  end

  always_comb begin
    w_in_legal = 1'b0;
    if (req_store_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: w_in_legal = 1'b1;
        3'b011:                 w_in_legal = (XLEN == 64);
        default:                w_in_legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_in_legal = 1'b1;
        3'b011, 3'b110:                         w_in_legal = (XLEN == 64);
        default:                                w_in_legal = 1'b0;
      endcase
    end
  end

  // Load data: the beat still on the bus is used directly so the result is ready on entry to RESP
  assign w_rd_lo   = (r_state == WAIT0) ? mem_rdata_i : r_rdata0;
  assign w_rd_hi   = (r_state == WAIT1) ? mem_rdata_i : '0;
  assign w_rd_cat  = {w_rd_hi, w_rd_lo} >> {r_off, 3'b000};
  assign w_rd_al   = w_rd_cat[XLEN-1:0];
  assign w_rd_left = w_rd_al << w_ext_sh;

  always_comb begin
    w_ext_sh = 7'd0;
    case (r_funct3[1:0])
      2'b00:   w_ext_sh = 7'(XLEN - 8);
      2'b01:   w_ext_sh = 7'(XLEN - 16);
      2'b10:   w_ext_sh = 7'(XLEN - 32);
      default: w_ext_sh = 7'd0;
    endcase
    w_load_val = r_funct3[2] ? (w_rd_left >> w_ext_sh)
                             : XLEN'($signed(w_rd_left) >>> w_ext_sh);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_next = w_reject ? RESP : REQ0;
      REQ0:    if (mem_gnt_i) w_next = WAIT0;
      WAIT0:   if (mem_rvalid_i) w_next = r_split ? REQ1 : RESP;
      REQ1:    if (mem_gnt_i) w_next = WAIT1;
      WAIT1:   if (mem_rvalid_i) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_store      <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= '0;
      r_base       <= '0;
      r_be2        <= '0;
      r_wdata2     <= '0;
      r_split      <= 1'b0;
      r_rdata0     <= '0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store_i;
        r_funct3 <= funct3_i;
        r_off    <= w_in_off;
        r_base   <= {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
        r_be2    <= w_in_be2;
        r_wdata2 <= w_in_wdata2;
        r_split  <= w_in_split;
      end
      if (r_state == WAIT0 && mem_rvalid_i) r_rdata0 <= mem_rdata_i;
      if (w_next == RESP && r_state != RESP) begin
        r_resp_error <= (r_state == IDLE);
        r_resp_rdata <= (r_state == IDLE || r_store) ? '0 : w_load_val;
      end
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign resp_valid_o = (r_state == RESP);
  assign resp_rdata_o = r_resp_rdata;
  assign resp_error_o = r_resp_error;

  // Bus outputs come straight from state so a reset drops the request without waiting for a clock
  always_comb begin
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_byteenable_o = '0;
    mem_wdata_o      = '0;
    if (r_state == REQ0) begin
      mem_req_o        = 1'b1;
      mem_we_o         = r_store;
      mem_addr_o       = r_base;
      mem_byteenable_o = r_be2[BE_WIDTH-1:0];
      mem_wdata_o      = r_wdata2[XLEN-1:0];
    end else if (r_state == REQ1) begin
      mem_req_o        = 1'b1;
      mem_we_o         = r_store;
      mem_addr_o       = r_base + XLEN'(BE_WIDTH);
      mem_byteenable_o = r_be2[BE2_W-1:BE_WIDTH];
      mem_wdata_o      = r_wdata2[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: doc/mod_mem_lsu_split.md
Name: mod_mem_lsu_split

Overview:
Parametrised load/store access unit, successor to the combinational byte-enable generator. It accepts one load/store request at a time and emits aligned bus beats with byte enables and lane-shifted store data. It extracts and sign/zero-extends load data. Accesses that cross a word boundary are split into two sequential aligned beats instead of being truncated. Sits between the execute/memory stage and the data-memory bus.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
BE_WIDTH, XLEN/8, derived byte-enable width (localparam).
SPLIT_MISALIGNED, 1, 1 = split boundary-crossing accesses into two beats; 0 = reject them with an error response.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  unit idle, can accept a request
req_store_i  in  1  1 = store, 0 = load
funct3_i  in  3  RISC-V load/store funct3
addr_i  in  XLEN  unaligned byte address
wdata_i  in  XLEN  store data, right-justified
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  XLEN  extended load data (0 for stores and errors)
resp_error_o  out  1  access rejected (illegal funct3 or rejected misalignment)
mem_req_o  out  1  bus beat request
mem_we_o  out  1  beat is a write
mem_addr_o  out  XLEN  aligned beat address
mem_byteenable_o  out  BE_WIDTH  beat byte enables
mem_wdata_o  out  XLEN  lane-shifted beat write data
mem_gnt_i  in  1  beat accepted by bus
mem_rvalid_i  in  1  beat completed (read data valid for loads, ack for stores)
mem_rdata_i  in  XLEN  beat read data

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is asynchronous, active-high.
- Reset values: state IDLE; req_ready_o=1; mem_req_o, mem_we_o, resp_valid_o, resp_error_o=0; mem_addr_o, mem_byteenable_o, mem_wdata_o, resp_rdata_o=0.
- Reset mid-operation: the transfer is abandoned and the bus request drops immediately (asynchronous). No response is produced. A late mem_rvalid_i arriving in IDLE is ignored.
- Handshake: a request is accepted on req_valid_i && req_ready_o. At acceptance, funct3, addr, wdata and store are captured.
- req_ready_o=1 only in IDLE.
- resp_valid_o is a single-cycle pulse in RESP and has no backpressure.
- resp_rdata_o and resp_error_o hold their value until the next RESP.
- Legal funct3 values:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101; LD 011 and LWU 110 only when XLEN=64.
  - Stores: SB 000, SH 001, SW 010; SD 011 only when XLEN=64.
  - Anything else is illegal.
- Geometry: size = 1/2/4/8 bytes; off = addr mod BE_WIDTH; base = addr with the low log2(BE_WIDTH) bits cleared.
  - be2 = ((1<<size)-1) << off, computed in 2*BE_WIDTH bits. The low half is the beat0 enable, the high half is the beat1 enable.
  - split = (high half != 0).
  - Beat1 address = base + BE_WIDTH, wrapping modulo 2^XLEN.
- Store data: wdata << 8*off, computed in 2*XLEN bits. The low half goes to beat0, the high half to beat1.
- Load data: {rdata1, rdata0} >> 8*off. The low size bytes are then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU); LD is taken as-is.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE -> REQ0 on accept.
  - IDLE -> RESP directly (error=1, no bus traffic) if funct3 is illegal, or if split && SPLIT_MISALIGNED=0.
  - REQn: mem_req_o=1. Address, enables, data and we are held stable until mem_gnt_i; on gnt -> WAITn.
  - WAITn: on mem_rvalid_i, capture rdata. From WAIT0 go to REQ1 if split, else to RESP; from WAIT1 go to RESP.
  - RESP -> IDLE.
- mem_rvalid_i is never expected in the same cycle as its own gnt; if it arrives there, it is ignored.
- Outside REQn, mem_req_o=0 and mem_byteenable_o=0.
- Latency (aligned, gnt in first REQ cycle, rvalid one cycle later): accept at T, resp_valid_o at T+3. A split access adds 2 cycles.

Test Plan:
1. XLEN=32, LW addr 0x100, gnt immediate, rdata 0xDEADBEEF -> one beat at addr 0x100, be 1111; resp_rdata_o 0xDEADBEEF at T+3; error 0.
2. LH addr 0x103; rdata0 0xAB000000, rdata1 0x000000CD -> beat0 0x100/be 1000, beat1 0x104/be 0001; resp 0xFFFFCDAB. Same with LHU -> 0x0000CDAB.
3. SW addr 0x102, wdata 0x11223344 -> beat0 0x100/be 1100/wdata 0x33440000 with we=1; beat1 0x104/be 0011/wdata 0x00001122; resp_rdata_o 0.
4. SW addr 0xFFFFFFFE -> beat0 0xFFFFFFFC/be 1100, beat1 0x00000000/be 0011 (wrap). Hold mem_gnt_i low 3 cycles in REQ1 -> addr, be and wdata stable throughout.
5. Error paths: SPLIT_MISALIGNED=0, LW 0x101 -> no mem_req_o, resp_valid_o with error=1 at T+1. Separately, XLEN=32 funct3 011 -> same error response. With XLEN=64, LD 0x104 -> split with be 11110000 / 00001111.
6. Assert rst_i during WAIT1 -> mem_req_o/resp_valid_o 0 immediately. After release, req_ready_o=1; a stray mem_rvalid_i produces no response; the next LW completes normally.
